resource_lock_scheduler: RTL

//  Round-robin lock controller for a shared resource (bus, memory port, engine).
//  The requester granted the resource keeps it until it releases it, drops its

---
 rtl/resource_lock_scheduler.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/resource_lock_scheduler.sv
// Round-robin lock controller: one owner at a time, hold-limit revoke,
// and an idle guard gap after every release before the next grant.
module resource_lock_scheduler #(
    parameter int NUM_PORTS  = 4,
    parameter int MAX_HOLD   = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_PORTS-1:0]         request,
    input  logic [NUM_PORTS-1:0]         done,
    output logic [NUM_PORTS-1:0]         grant,
    output logic [$clog2(NUM_PORTS)-1:0] grant_id,
    output logic                         valid_grant,
    output logic                         timeout,
    output logic [$clog2(NUM_PORTS)-1:0] timeout_id
);
    localparam int IW = $clog2(NUM_PORTS);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, OWNED, GAP} state_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        rr_q, rr_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [IW-1:0]        id_q, id_d;
    logic                 valid_q, valid_d;
    logic                 to_q, to_d;
    logic [IW-1:0]        tid_q, tid_d;

    logic                 pick_found;
    logic [IW-1:0]        pick_idx;
    logic [IW-1:0]        pick_nxt;
    logic [IW:0]          cand;
    logic                 rel;
    logic                 at_max;

    // Scan from the farthest offset down so the nearest hit to rr_q wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            cand = {1'b0, rr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(NUM_PORTS)) begin
                cand = cand - (IW+1)'(NUM_PORTS);
            end
            if (request[cand[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IW-1:0];
            end
        end
    end

    assign pick_nxt = (pick_idx == IW'(NUM_PORTS - 1)) ? '0 : pick_idx + IW'(1);
    assign rel      = done[id_q] | ~request[id_q];
    assign at_max   = (hold_q == HW'(MAX_HOLD));

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        grant_d = grant_q;
        id_d    = id_q;
        valid_d = valid_q;
        to_d    = 1'b0;
        tid_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = OWNED;
                    grant_d = NUM_PORTS'(1) << pick_idx;
                    id_d    = pick_idx;
                    valid_d = 1'b1;
                    hold_d  = HW'(1);
                    rr_d    = pick_nxt;
                end
            end
            OWNED: begin
                if (rel || at_max) begin
                    state_d = GAP;
                    grant_d = '0;
                    id_d    = '0;
                    valid_d = 1'b0;
                    hold_d  = '0;
                    gap_d   = GW'(1);
                    // A release in the limit cycle is a normal release.
                    if (!rel) begin
                        to_d  = 1'b1;
                        tid_d = id_q;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            GAP: begin
                if (gap_q == GW'(GAP_CYCLES)) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            hold_q  <= '0;
            gap_q   <= '0;
            grant_q <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
            to_q    <= 1'b0;
            tid_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            to_q    <= to_d;
            tid_q   <= tid_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = id_q;
    assign valid_grant = valid_q;
    assign timeout     = to_q;
    assign timeout_id  = tid_q;
endmodule
